link_monitor_multi: RTL and testbench

Parametrised, multi-channel successor to the Clause 147 link monitor state diagram. It adds a fully synchronous implementation, per-channel link-up qualification and link-down debounce timers, link-change event pulses, saturating link-drop counters, and aggregate status. It sits between the per-channel PCS/PMA status sources and management/PHY control logic in the multi-drop/multi-port Clause 147 models.

---
 rtl/link_monitor_multi.sv | 138 +++++++++++++
 tb/tb_link_monitor_multi.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/link_monitor_multi.sv
`default_nettype none
// ============================================================================
// Module   : link_monitor_multi
// Brief    : Multi-channel link monitor with up-qualification, down-debounce,
//            change pulses, saturating drop counters and aggregate status.
// Revision : 1.0 - initial release
// ============================================================================
module link_monitor_multi #(
  parameter int NUM_CH      = 4,
  parameter int UP_CYCLES   = 8,
  parameter int DOWN_CYCLES = 4,
  parameter int DROP_W      = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_CH-1:0]        pma_reset_i,
  input  logic [NUM_CH-1:0]        link_control_i,
  input  logic [NUM_CH-1:0]        pcs_status_i,
  input  logic [NUM_CH-1:0]        loc_rcv_status_i,
  input  logic                     clr_drops_i,
  output logic [NUM_CH-1:0]        link_status_o,
  output logic [NUM_CH-1:0]        link_change_o,
  output logic                     any_link_up_o,
  output logic                     all_link_up_o,
  output logic [2*NUM_CH-1:0]      state_vec_o,
  output logic [DROP_W*NUM_CH-1:0] drop_count_o
);

  localparam int C_MAX_CYC = (UP_CYCLES > DOWN_CYCLES) ? UP_CYCLES : DOWN_CYCLES;
  localparam int C_TW      = $clog2(C_MAX_CYC + 1);

  typedef enum logic [1:0] {
    LINK_DOWN = 2'b00,
    LINK_QUAL = 2'b01,
    LINK_UP   = 2'b10,
    LINK_HOLD = 2'b11
  } state_t;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      state_t            state_q, state_d;
      logic [C_TW-1:0]   timer_q, timer_d;
      logic [C_TW-1:0]   w_timer_inc;
      logic              status_q, status_d;
      logic              change_q;
      logic [DROP_W-1:0] drops_q;
      logic              w_good, w_force_dn;

      assign w_good      = ~pcs_status_i[i] & loc_rcv_status_i[i];
      assign w_force_dn  = pma_reset_i[i] | link_control_i[i];
      assign w_timer_inc = timer_q + C_TW'(1);

      always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (w_force_dn) begin
          state_d = LINK_DOWN;
          timer_d = '0;
        end else begin
          case (state_q)
            LINK_DOWN: if (w_good) begin
              if (UP_CYCLES == 1) begin
                state_d = LINK_UP;
                timer_d = '0;
              end else begin
                state_d = LINK_QUAL;
                timer_d = C_TW'(1);
              end
            end
            LINK_QUAL: if (!w_good) begin
              state_d = LINK_DOWN;
              timer_d = '0;
            end else if (int'(w_timer_inc) == UP_CYCLES) begin
              state_d = LINK_UP;
              timer_d = '0;
            end else begin
              timer_d = w_timer_inc;
            end
            LINK_UP: if (!w_good) begin
              if (DOWN_CYCLES == 1) begin
                state_d = LINK_DOWN;
                timer_d = '0;
              end else begin
                state_d = LINK_HOLD;
                timer_d = C_TW'(1);
              end
            end
            LINK_HOLD: if (w_good) begin
              // Recovery inside the debounce window is silent: no event, no drop.
              state_d = LINK_UP;
              timer_d = '0;
            end else if (int'(w_timer_inc) == DOWN_CYCLES) begin
              state_d = LINK_DOWN;
              timer_d = '0;
            end else begin
              timer_d = w_timer_inc;
            end
            default: begin
              state_d = LINK_DOWN;
              timer_d = '0;
            end
          endcase
        end
        status_d = (state_d == LINK_UP) || (state_d == LINK_HOLD);
      end

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          state_q  <= LINK_DOWN;
          timer_q  <= '0;
          status_q <= 1'b0;
          change_q <= 1'b0;
          drops_q  <= '0;
        end else begin
          state_q  <= state_d;
          timer_q  <= timer_d;
          status_q <= status_d;
          change_q <= status_d ^ status_q;
          if (clr_drops_i) begin
            drops_q <= '0;
          end else if (status_q && !status_d && (drops_q != {DROP_W{1'b1}})) begin
            drops_q <= drops_q + DROP_W'(1);
          end
        end
      end

      assign link_status_o[i]                   = status_q;
      assign link_change_o[i]                   = change_q;
      assign state_vec_o[2*i +: 2]              = state_q;
      assign drop_count_o[DROP_W*i +: DROP_W]   = drops_q;
    end
  endgenerate

  assign any_link_up_o = |link_status_o;
  assign all_link_up_o = &link_status_o;

endmodule
`default_nettype wire

// File: tb/tb_link_monitor_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_link_monitor_multi
// Brief    : Directed scoreboard bench for link_monitor_multi (4 ch, 2-bit drops).
// Revision : 1.0 - initial release
// ============================================================================
module tb_link_monitor_multi;

  localparam int NUM_CH      = 4;
  localparam int UP_CYCLES   = 8;
  localparam int DOWN_CYCLES = 4;
  localparam int DROP_W      = 2;
  localparam int DROP_MAX    = (1 << DROP_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH-1:0]        pma = '0;
  logic [NUM_CH-1:0]        lctl = '0;
  logic [NUM_CH-1:0]        pcs = '0;
  logic [NUM_CH-1:0]        rcv = '0;
  logic                     clr = 1'b0;
  logic [NUM_CH-1:0]        ls, lc;
  logic                     any_up, all_up;
  logic [2*NUM_CH-1:0]      sv;
  logic [DROP_W*NUM_CH-1:0] dc;

  link_monitor_multi #(
    .NUM_CH(NUM_CH), .UP_CYCLES(UP_CYCLES), .DOWN_CYCLES(DOWN_CYCLES), .DROP_W(DROP_W)
  ) dut (
    .clk_i(clk), .reset_i(rst), .pma_reset_i(pma), .link_control_i(lctl),
    .pcs_status_i(pcs), .loc_rcv_status_i(rcv), .clr_drops_i(clr),
    .link_status_o(ls), .link_change_o(lc), .any_link_up_o(any_up),
    .all_link_up_o(all_up), .state_vec_o(sv), .drop_count_o(dc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH-1:0]        ls;
    logic [NUM_CH-1:0]        lc;
    logic                     any_up;
    logic                     all_up;
    logic [2*NUM_CH-1:0]      sv;
    logic [DROP_W*NUM_CH-1:0] dc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: tracks consecutive good / bad runs rather than a state machine.
  bit m_up [NUM_CH];
  int m_gr [NUM_CH];
  int m_br [NUM_CH];
  int m_drop [NUM_CH];
  bit m_chg [NUM_CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_and_push();
    exp_t e;
    for (int i = 0; i < NUM_CH; i++) begin
      bit prev, good, frc;
      prev = m_up[i];
      good = !pcs[i] && rcv[i];
      frc  = pma[i] || lctl[i];
      if (rst) begin
        m_up[i] = 0; m_gr[i] = 0; m_br[i] = 0; m_drop[i] = 0; m_chg[i] = 0;
      end else begin
        if (frc) begin
          m_up[i] = 0; m_gr[i] = 0; m_br[i] = 0;
        end else if (good) begin
          m_br[i] = 0;
          if (!m_up[i]) begin
            m_gr[i]++;
            if (m_gr[i] == UP_CYCLES) begin m_up[i] = 1; m_gr[i] = 0; end
          end
        end else begin
          m_gr[i] = 0;
          if (m_up[i]) begin
            m_br[i]++;
            if (m_br[i] == DOWN_CYCLES) begin m_up[i] = 0; m_br[i] = 0; end
          end
        end
        m_chg[i] = (prev != m_up[i]);
        if (clr) m_drop[i] = 0;
        else if (prev && !m_up[i] && m_drop[i] < DROP_MAX) m_drop[i]++;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      e.ls[i] = m_up[i];
      e.lc[i] = m_chg[i];
      e.sv[2*i +: 2] = m_up[i] ? (m_br[i] != 0 ? 2'b11 : 2'b10)
                               : (m_gr[i] != 0 ? 2'b01 : 2'b00);
      e.dc[DROP_W*i +: DROP_W] = DROP_W'(m_drop[i]);
    end
    e.any_up = |e.ls;
    e.all_up = &e.ls;
    q.push_back(e);
  endtask

  task automatic step(input string tag);
    exp_t e;
    model_and_push();
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, ".link_status"}, 32'(ls), 32'(e.ls));
    chk({tag, ".link_change"}, 32'(lc), 32'(e.lc));
    chk({tag, ".any_link_up"}, 32'(any_up), 32'(e.any_up));
    chk({tag, ".all_link_up"}, 32'(all_up), 32'(e.all_up));
    chk({tag, ".state_vec"}, 32'(sv), 32'(e.sv));
    chk({tag, ".drop_count"}, 32'(dc), 32'(e.dc));
  endtask

  task automatic steps(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pcs = '1; rcv = '0;
    steps("reset", 2);
    chk("reset.ls_zero", 32'(ls), 32'h0);
    chk("reset.dc_zero", 32'(dc), 32'h0);
    rst = 1'b0;

    // Channel 0 qualification: rises exactly on the 8th good edge
    pcs[0] = 1'b0; rcv[0] = 1'b1;
    steps("qual0", UP_CYCLES - 1);
    chk("qual0.not_yet_up", 32'(ls[0]), 32'h0);
    step("qual0");
    chk("qual0.up", 32'(ls[0]), 32'h1);
    chk("qual0.change", 32'(lc[0]), 32'h1);
    chk("qual0.any", 32'(any_up), 32'h1);
    chk("qual0.all", 32'(all_up), 32'h0);
    chk("qual0.state", 32'(sv[1:0]), 32'h2);
    step("qual0.settle");
    chk("qual0.change_1cyc", 32'(lc[0]), 32'h0);

    // Channel 1 aborted qualification then full run
    pcs[1] = 1'b0; rcv[1] = 1'b1;
    steps("abort1", 5);
    rcv[1] = 1'b0;
    step("abort1.bad");
    chk("abort1.state_down", 32'(sv[3:2]), 32'h0);
    rcv[1] = 1'b1;
    steps("abort1.rerun", UP_CYCLES - 1);
    chk("abort1.not_yet_up", 32'(ls[1]), 32'h0);
    step("abort1.rerun");
    chk("abort1.up", 32'(ls[1]), 32'h1);

    // Channel 0 debounce: short glitch is absorbed, long one drops
    pcs[0] = 1'b1;
    steps("deb0.glitch", DOWN_CYCLES - 1);
    chk("deb0.hold_state", 32'(sv[1:0]), 32'h3);
    chk("deb0.still_up", 32'(ls[0]), 32'h1);
    pcs[0] = 1'b0;
    step("deb0.recover");
    chk("deb0.no_drop", 32'(dc[1:0]), 32'h0);
    chk("deb0.no_change", 32'(lc[0]), 32'h0);
    pcs[0] = 1'b1;
    steps("deb0.fail", DOWN_CYCLES - 1);
    chk("deb0.up_before_last", 32'(ls[0]), 32'h1);
    step("deb0.fail");
    chk("deb0.down", 32'(ls[0]), 32'h0);
    chk("deb0.drop1", 32'(dc[1:0]), 32'h1);
    rcv[0] = 1'b0; pcs[0] = 1'b0;

    // Channel 2 forced drop mid-hold, then full requalification
    pcs[2] = 1'b0; rcv[2] = 1'b1;
    steps("force2.qual", UP_CYCLES);
    rcv[2] = 1'b0;
    step("force2.hold");
    lctl[2] = 1'b1;
    step("force2.disable");
    chk("force2.state", 32'(sv[5:4]), 32'h0);
    chk("force2.ls", 32'(ls[2]), 32'h0);
    chk("force2.change", 32'(lc[2]), 32'h1);
    chk("force2.drop", 32'(dc[5:4]), 32'h1);
    lctl[2] = 1'b0; rcv[2] = 1'b1;
    steps("force2.requal", UP_CYCLES - 1);
    chk("force2.not_yet_up", 32'(ls[2]), 32'h0);
    step("force2.requal");
    chk("force2.up", 32'(ls[2]), 32'h1);

    // Channel 3 drop counter saturation, then clear racing a drop
    pcs[3] = 1'b0; rcv[3] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      steps("sat3.qual", UP_CYCLES);
      pma[3] = 1'b1;
      step("sat3.drop");
      pma[3] = 1'b0;
      chk($sformatf("sat3.count%0d", c), 32'(dc[7:6]), (c < 3) ? 32'(c + 1) : 32'h3);
    end
    steps("clr3.qual", UP_CYCLES);
    pma[3] = 1'b1; clr = 1'b1;
    step("clr3.race");
    pma[3] = 1'b0; clr = 1'b0;
    chk("clr3.all_zero", 32'(dc), 32'h0);

    // All channels up, then synchronous reset mid-run and requalification
    pcs = '0; rcv = '1; pma = '0; lctl = '0;
    steps("all.qual", UP_CYCLES);
    chk("all.up", 32'(all_up), 32'h1);
    steps("all.mid", 3);
    rst = 1'b1;
    step("all.reset");
    chk("all.reset_ls", 32'(ls), 32'h0);
    chk("all.reset_sv", 32'(sv), 32'h0);
    chk("all.reset_any", 32'(any_up), 32'h0);
    rst = 1'b0;
    steps("all.requal", UP_CYCLES - 1);
    chk("all.requal_not_yet", 32'(ls), 32'h0);
    step("all.requal");
    chk("all.requal_up", 32'(ls), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
